// File: rtl/opcode_issue_queue.sv
// ---------------------------------------------------------------------------
// opcode_issue_queue
//   Small first-word-fall-through FIFO of (opcode, id) commands sitting in
//   front of a downstream decoder. It also keeps a saturating count of the
//   "invalid" (opcode = 1) entries that have been issued downstream.
//
// Ports
//   clock        sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_valid     upstream command present
//   in_ready     queue has room (count < DEPTH); independent of out_ready
//   in_opcode    command opcode (0 = id dispatch, 1 = invalid)
//   in_id        command id
//   flush        synchronous discard of every queued entry
//   out_valid    head entry present (count > 0)
//   out_ready    downstream accepts the head entry
//   out_opcode   head opcode, forced to 0 when out_valid = 0
//   out_id       head id, forced to 0 when out_valid = 0
//   count        entries held, 0..DEPTH
//   invalid_cnt  saturating count of issued opcode-1 entries (survives flush)
//
// DEPTH must be a power of two between 2 and 16 so that the pointers wrap
// naturally at their $clog2(DEPTH)-bit width.
// ---------------------------------------------------------------------------
module opcode_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_opcode,
  input  logic                     in_id,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_opcode,
  output logic                     out_id,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               invalid_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry layout: {opcode, id}. Storage is data only and is never reset;
  // stale contents are hidden by the out_valid masking below.
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic [1:0]    head;

  // Full/empty come only from the registered count, so there is no
  // combinational path from in_* to out_* or from out_ready to in_ready.
  assign in_ready   = (count < CW'(DEPTH));
  assign out_valid  = (count != '0);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;

  assign head       = mem[rd_ptr];
  assign out_opcode = out_valid & head[1];
  assign out_id     = out_valid & head[0];

  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= {in_opcode, in_id};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      invalid_cnt <= '0;
    end else begin
      // A pop that coincides with flush is not an issue, so it is not counted.
      if (pop && !flush && head[1] && (invalid_cnt != 8'hFF)) begin
        invalid_cnt <= invalid_cnt + 8'd1;
      end

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push) begin
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/opcode_issue_queue.md
OPCODE_ISSUE_QUEUE -- requirements
Module: opcode_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; SHALL be a power of two, 2 to 16.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset; assertion SHALL clear state immediately, deassertion SHALL be sampled on clock.
REQ-004 in_valid  input  1  upstream command present.
REQ-005 in_ready  output  1  queue can accept a command this cycle.
REQ-006 in_opcode  input  1  command opcode (0 = id dispatch, 1 = invalid).
REQ-007 in_id  input  1  command id, meaningful when opcode = 0.
REQ-008 flush  input  1  synchronous discard of all queued entries.
REQ-009 out_valid  output  1  head entry presented to the downstream decoder.
REQ-010 out_ready  input  1  downstream decoder accepts the head entry.
REQ-011 out_opcode  output  1  head entry opcode.
REQ-012 out_id  output  1  head entry id.
REQ-013 count  output  $clog2(DEPTH)+1  entries currently held, 0..DEPTH.
REQ-014 invalid_cnt  output  8  saturating count of issued entries with opcode = 1.

Function
REQ-015 Push SHALL occur when in_valid and in_ready are both 1 at a clock edge; pop SHALL occur when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL be 1 exactly when count < DEPTH; it SHALL NOT depend combinationally on out_ready (no bypass when full).
REQ-017 out_valid SHALL be 1 exactly when count > 0; out_opcode/out_id SHALL reflect the oldest entry (first-word fall-through) and SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-018 Latency: an entry pushed into an empty queue at edge N SHALL appear on out_* with out_valid = 1 in the cycle following edge N; there SHALL be no same-cycle input-to-output path.
REQ-019 Ordering SHALL be strict FIFO; read/write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-021 Push with count = DEPTH SHALL be impossible (in_ready = 0); pop with count = 0 SHALL be impossible (out_valid = 0); neither condition SHALL alter state.
REQ-022 count SHALL increment on push-only, decrement on pop-only, hold otherwise.
REQ-023 flush = 1 at an edge SHALL set count, read pointer and write pointer to 0, overriding any push or pop in that cycle; the entry in a concurrent push SHALL be discarded and a concurrent pop SHALL NOT be counted.
REQ-024 invalid_cnt SHALL increment by 1 on each pop whose head opcode = 1, SHALL saturate at 255, and SHALL NOT be cleared by flush.
REQ-025 out_opcode/out_id SHALL be 0 whenever out_valid = 0.

Reset
REQ-026 While reset_n = 0: count = 0, pointers = 0, invalid_cnt = 0, out_valid = 0, out_opcode = 0, out_id = 0, in_ready = 1.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries regardless of handshake state; the first push after reset release SHALL be stored at entry 0.
REQ-028 Storage array contents need not be reset; outputs SHALL be masked per REQ-025.

Verification
REQ-029 Push (0,0),(0,1),(1,0) with out_ready = 0 -> count = 3; then out_ready = 1 for 3 cycles -> outputs (0,0),(0,1),(1,0) in order, count = 0, invalid_cnt = 1.
REQ-030 Push 4 entries with out_ready = 0 (DEPTH = 4) -> in_ready = 0, count = 4; 5th in_valid held -> not accepted; one pop -> in_ready = 1 next cycle.
REQ-031 Steady in_valid = out_ready = 1 for 20 cycles, alternating opcode -> count stays at 1 after first cycle, pointers wrap, every input observed once in order, invalid_cnt = 10.
REQ-032 count = 3, flush = 1 with concurrent push and pop -> next cycle count = 0, out_valid = 0, pushed entry never emitted, invalid_cnt unchanged.
REQ-033 300 pops of opcode-1 entries -> invalid_cnt reaches 255 and holds.
REQ-034 count = 2, reset_n pulsed low asynchronously between edges -> outputs clear immediately; after release push (0,1) -> out = (0,1), count = 1.
